// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the regfile write-port arbiter.
// WB_ARB_PERF_EN (default off) enables perf counters in wb_port_arbiter.
package wb_port_arbiter_pkg;

   localparam int WB_REQ_WID = 69;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_PIPE = 2'd1,
      GNT_LL   = 2'd2
   } gnt_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  dest;
      logic [31:0] wdata;
   } wb_req_t;

   function automatic wb_req_t mk_req(
      input logic [31:0] pc,
      input logic [4:0]  dest,
      input logic [31:0] wdata
   );
      wb_req_t r;
      r.pc    = pc;
      r.dest  = dest;
      r.wdata = wdata;
      return r;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Requester handshakes, regfile write bus and debug trace of the arbiter.
interface wb_port_arbiter_if;

   logic        pipe_valid;
   logic        pipe_ready;
   logic [4:0]  pipe_dest;
   logic [31:0] pipe_wdata;
   logic [31:0] pipe_pc;

   logic        ll_valid;
   logic        ll_ready;
   logic [4:0]  ll_dest;
   logic [31:0] ll_wdata;
   logic [31:0] ll_pc;
   logic        ll_pending;

   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_we;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;

   modport slave (
      input  pipe_valid, pipe_dest, pipe_wdata, pipe_pc,
      input  ll_valid, ll_dest, ll_wdata, ll_pc,
      output pipe_ready, ll_ready, ll_pending,
      output rf_we, rf_waddr, rf_wdata,
      output debug_wb_pc, debug_wb_rf_we,
      output debug_wb_rf_wnum, debug_wb_rf_wdata
   );

   modport master (
      output pipe_valid, pipe_dest, pipe_wdata, pipe_pc,
      output ll_valid, ll_dest, ll_wdata, ll_pc,
      input  pipe_ready, ll_ready, ll_pending,
      input  rf_we, rf_waddr, rf_wdata,
      input  debug_wb_pc, debug_wb_rf_we,
      input  debug_wb_rf_wnum, debug_wb_rf_wdata
   );

endinterface

// File: rtl/wb_sync_fifo.sv
// Synchronous FIFO: valid/ready push, pop on grant, occupancy count.
module wb_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_valid,
   output logic                   push_ready,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // ready comes from the current count only: a same-cycle pop never
   // opens a slot for a push
   assign push_ready = (count != (PW+1)'(DEPTH));
   assign do_push    = push_valid && push_ready;
   assign do_pop     = pop && (count != '0);
   assign pop_data   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(do_push)
                        - (PW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: pipeline writeback vs buffered mul/div results.
// Define WB_ARB_PERF_EN to add saturating hold/full/LL-write counters.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int LL_DEPTH     = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst,
`ifdef WB_ARB_PERF_EN
   output logic [31:0]        perf_hold_cnt,
   output logic [31:0]        perf_llfull_cnt,
   output logic [31:0]        perf_ll_wr_cnt,
`endif
   wb_port_arbiter_if.slave   bus
);

   localparam int CW = $clog2(LL_DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   wb_req_t       pipe_req;
   wb_req_t       ll_req;
   wb_req_t       ll_head;
   wb_req_t       gnt_req;
   logic [CW-1:0] ll_cnt;
   logic          ll_pending;
   logic          ll_ready;
   logic          ll_pop;
   logic          hold;
   logic          hold_d;
   logic [SW-1:0] starve_cnt;
   logic [SW-1:0] starve_d;
   gnt_e          gnt;

   assign pipe_req   = mk_req(bus.pipe_pc, bus.pipe_dest, bus.pipe_wdata);
   assign ll_req     = mk_req(bus.ll_pc, bus.ll_dest, bus.ll_wdata);
   assign ll_pending = (ll_cnt != '0);
   assign ll_pop     = (gnt == GNT_LL);

   wb_sync_fifo #(
      .WIDTH (WB_REQ_WID),
      .DEPTH (LL_DEPTH)
   ) u_ll_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_valid (bus.ll_valid),
      .push_ready (ll_ready),
      .push_data  (ll_req),
      .pop        (ll_pop),
      .pop_data   (ll_head),
      .count      (ll_cnt)
   );

   always_comb begin
      gnt = GNT_NONE;
      if (hold && ll_pending)
         gnt = GNT_LL;
      else if (bus.pipe_valid && !hold)
         gnt = GNT_PIPE;
      else if (ll_pending)
         gnt = GNT_LL;
   end

   assign gnt_req = (gnt == GNT_PIPE) ? pipe_req : ll_head;

   // count consecutive losses of a waiting LL head; hitting the limit
   // stalls the pipeline for the following cycle
   always_comb begin
      starve_d = starve_cnt;
      if (gnt == GNT_LL || !ll_pending)
         starve_d = '0;
      else if (gnt == GNT_PIPE)
         starve_d = starve_cnt + SW'(1);
   end

   assign hold_d = (starve_d == SW'(STARVE_LIMIT));

   always_ff @(posedge clk) begin
      if (rst) begin
         hold            <= 1'b0;
         starve_cnt      <= '0;
         bus.rf_we       <= 1'b0;
         bus.rf_waddr    <= '0;
         bus.rf_wdata    <= '0;
         bus.debug_wb_pc <= '0;
      end else begin
         hold       <= hold_d;
         starve_cnt <= starve_d;
         bus.rf_we  <= (gnt != GNT_NONE) && (gnt_req.dest != 5'd0);
         if (gnt != GNT_NONE) begin
            bus.rf_waddr    <= gnt_req.dest;
            bus.rf_wdata    <= gnt_req.wdata;
            bus.debug_wb_pc <= gnt_req.pc;
         end
      end
   end

   assign bus.pipe_ready        = !hold;
   assign bus.ll_ready          = ll_ready;
   assign bus.ll_pending        = ll_pending;
   assign bus.debug_wb_rf_we    = {4{bus.rf_we}};
   assign bus.debug_wb_rf_wnum  = bus.rf_waddr;
   assign bus.debug_wb_rf_wdata = bus.rf_wdata;

`ifdef WB_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_hold_cnt   <= '0;
         perf_llfull_cnt <= '0;
         perf_ll_wr_cnt  <= '0;
      end else begin
         if (hold)
            perf_hold_cnt <= sat_inc(perf_hold_cnt);
         if (bus.ll_valid && !ll_ready)
            perf_llfull_cnt <= sat_inc(perf_llfull_cnt);
         if (gnt == GNT_LL)
            perf_ll_wr_cnt <= sat_inc(perf_ll_wr_cnt);
      end
   end
`endif

endmodule
